alu_pipe: RTL and testbench
===========================

# alu_pipe

Parametrised, handshaked execution unit for the EXE stage of the pipeline. Accepts one operation per cycle on a valid/ready input, registers the result and NZCV flags behind a valid/ready output, and holds the architectural status register internally so ADC/SBC read the committed carry. It adds an iterative multi-cycle MUL and a flush for branch squash.

## Interface
- WIDTH, 32: operand/result width, ≥ 8.
- MUL_EN, 1: 1 = MUL implemented; 0 = MUL treated as undefined command.
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous squash of in-flight work.
- in_valid  in  1  operation offered.
- in_ready  out  1  operation accepted when in_valid & in_ready.
- in_cmd  in  4  command code.
- in_a, in_b  in  WIDTH  operands.
- in_s  in  1  commit flags to status_reg.
- out_valid  out  1  result held.
- out_ready  in  1  consumer takes result when out_valid & out_ready.
- out_result  out  WIDTH  result.
- out_flags  out  4  {N,Z,C,V} computed for this result.
- status_reg  out  4  committed {N,Z,C,V}.

## Operation
- Commands: 0001 MOV (b), 1001 MVN (~b), 0010 ADD, 0011 ADC (a+b+C), 0100 SUB, 0101 SBC (a-b-!C), 0110 AND, 0111 ORR, 1000 EOR, 1100 CMP (a-b), 1110 TST (a&b), 1010 ADDR (a+b, no flags), 1111 MUL (low WIDTH bits of a*b). Others: result 0, no flag commit.
- Arithmetic is WIDTH+1 bits. Add C = carry out. Sub C = NOT borrow (a≥b unsigned → 1). V = signed overflow.
- Logic ops, MOV, MVN and MUL compute N and Z. They pass C and V through from status_reg.
- Z = (result == 0). N = result[WIDTH-1].
- Flag commit: status_reg ← out_flags on the edge the result loads the output register, if in_s. CMP and TST always commit. ADDR and undefined never commit.
- C used by ADC/SBC is status_reg at the accept edge.
- FSM: IDLE and MUL_BUSY.
  - IDLE, accepting a MUL → MUL_BUSY, counter = WIDTH-1.
  - MUL_BUSY performs one shift-add step per cycle.
  - At count 0 it loads the output register if the register is free, then goes to IDLE.
  - If the output register is not free, it waits in MUL_BUSY with the product held.
- in_ready = (state==IDLE) & !flush & (!out_valid | out_ready).
- Flush:
  - clears out_valid and aborts MUL_BUSY → IDLE.
  - No flags are committed that cycle. status_reg keeps prior value.

## Timing
- Reset values:
  - out_valid 0, out_result 0, out_flags 0, status_reg 0, state IDLE.
  - in_ready 1 with flush low.
- Single-cycle ops: accept at edge k → out_valid high after edge k; back-to-back throughput 1/cycle while out_ready = 1.
- MUL: accept at edge k → out_valid after edge k+WIDTH if out_ready held high; in_ready low throughout.
- out_result/out_flags stable while out_valid & !out_ready.
- Dependent ADDS then ADC issued on consecutive cycles: ADC sees the new C (commit and accept on separate edges).
- Simultaneous flush and in_valid: nothing accepted.
- Simultaneous flush and out_ready: output dropped.
- rst mid-MUL: immediate return to reset values, no partial result.

## Structure
- Package alu_pkg holds:
  - command localparams (CMD_MOV … CMD_MUL);
  - flag bit indices FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0;
  - FSM state encoding.
- Sub-module alu_mul_iter(WIDTH) holds the shift-add datapath: start, step, done, product.
- Not instantiated when MUL_EN=0.

## Test plan
- Reset, WIDTH=32: ADDS a=0x7FFFFFFF b=1 → result 0x80000000, flags N=1 Z=0 C=0 V=1, status_reg 1001.
- SUBS 5−5, then ADC 1+1 next cycle → first result 0 with Z=1 C=1; ADC result 3.
- MUL 0x10000 × 0x10000, out_ready=1 → in_ready low 32 cycles, result 0, Z=1, status C/V unchanged.
- ANDS 0xF0&0x0F with out_ready=0 for 3 cycles → out_valid stays 1, result 0 stable, in_ready 0, no second accept.
- Flush at MUL cycle 10 → out_valid never rises, state IDLE next cycle, status_reg unchanged, next ADD accepted.
- Command 1011 with in_s=1 → result 0, status_reg unchanged.

Source files
------------

// File: rtl/alu_pkg.sv
// ----------------------------------------------------------------
// alu_pkg: command codes, NZCV flag indices and FSM encoding for alu_pipe
// Revision: 1.0
// ----------------------------------------------------------------
`default_nettype none

package alu_pkg;

    localparam logic [3:0] CMD_MOV  = 4'b0001;
    localparam logic [3:0] CMD_ADD  = 4'b0010;
    localparam logic [3:0] CMD_ADC  = 4'b0011;
    localparam logic [3:0] CMD_SUB  = 4'b0100;
    localparam logic [3:0] CMD_SBC  = 4'b0101;
    localparam logic [3:0] CMD_AND  = 4'b0110;
    localparam logic [3:0] CMD_ORR  = 4'b0111;
    localparam logic [3:0] CMD_EOR  = 4'b1000;
    localparam logic [3:0] CMD_MVN  = 4'b1001;
    localparam logic [3:0] CMD_ADDR = 4'b1010;
    localparam logic [3:0] CMD_CMP  = 4'b1100;
    localparam logic [3:0] CMD_TST  = 4'b1110;
    localparam logic [3:0] CMD_MUL  = 4'b1111;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [0:0] {
        ST_IDLE     = 1'b0,
        ST_MUL_BUSY = 1'b1
    } state_t;

endpackage

`default_nettype wire

// File: rtl/alu_mul_iter.sv
// ----------------------------------------------------------------
// alu_mul_iter: iterative shift-add multiplier keeping the low WIDTH bits
// Revision: 1.0
// ----------------------------------------------------------------
`default_nettype none

module alu_mul_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             step,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    localparam int CNT_W = $clog2(WIDTH);

    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;

    // start performs the first partial product, so WIDTH-1 further steps complete it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count  <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
        end else if (start) begin
            acc    <= b[0] ? a : '0;
            mcand  <= a << 1;
            mplier <= b >> 1;
            count  <= CNT_W'(WIDTH - 1);
        end else if (step && (count != '0)) begin
            acc    <= acc + (mplier[0] ? mcand : '0);
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count - CNT_W'(1);
        end
    end

    assign done    = (count == '0);
    assign product = acc;

endmodule

`default_nettype wire

// File: rtl/alu_pipe.sv
// ----------------------------------------------------------------
// alu_pipe: handshaked EXE-stage ALU with NZCV status register and iterative MUL
// Revision: 1.0
// ----------------------------------------------------------------
`default_nettype none

module alu_pipe #(
    parameter int WIDTH  = 32,
    parameter bit MUL_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_cmd,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_s,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [3:0]       out_flags,
    output logic [3:0]       status_reg
);

    import alu_pkg::*;

    state_t           state;
    logic             accept;
    logic             out_free;
    logic             is_mul;
    logic             mul_s;
    logic             mul_done;
    logic [WIDTH-1:0] mul_product;
    logic [3:0]       mul_flags;
    logic             is_sub;
    logic             is_arith;
    logic             carry_in;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] alu_res;
    logic [3:0]       alu_flags;
    logic             alu_commit;

    assign out_free = !out_valid || out_ready;
    assign in_ready = (state == ST_IDLE) && !flush && out_free;
    assign accept   = in_valid && in_ready;
    assign is_mul   = MUL_EN && (in_cmd == CMD_MUL);

    // Subtraction is a + ~b + cin, so C comes out as NOT borrow
    always_comb begin
        is_sub   = (in_cmd == CMD_SUB) || (in_cmd == CMD_SBC) || (in_cmd == CMD_CMP);
        is_arith = is_sub || (in_cmd == CMD_ADD) || (in_cmd == CMD_ADC) || (in_cmd == CMD_ADDR);
        op_b     = is_sub ? ~in_b : in_b;
        case (in_cmd)
            CMD_ADC, CMD_SBC: carry_in = status_reg[FLAG_C];
            CMD_SUB, CMD_CMP: carry_in = 1'b1;
            default:          carry_in = 1'b0;
        endcase
        sum = {1'b0, in_a} + {1'b0, op_b} + {{WIDTH{1'b0}}, carry_in};

        alu_res    = '0;
        alu_commit = 1'b0;
        case (in_cmd)
            CMD_MOV:                            begin alu_res = in_b;           alu_commit = in_s; end
            CMD_MVN:                            begin alu_res = ~in_b;          alu_commit = in_s; end
            CMD_ADD, CMD_ADC, CMD_SUB, CMD_SBC: begin alu_res = sum[WIDTH-1:0]; alu_commit = in_s; end
            CMD_ADDR:                           begin alu_res = sum[WIDTH-1:0]; end
            CMD_CMP:                            begin alu_res = sum[WIDTH-1:0]; alu_commit = 1'b1; end
            CMD_AND:                            begin alu_res = in_a & in_b;    alu_commit = in_s; end
            CMD_ORR:                            begin alu_res = in_a | in_b;    alu_commit = in_s; end
            CMD_EOR:                            begin alu_res = in_a ^ in_b;    alu_commit = in_s; end
            CMD_TST:                            begin alu_res = in_a & in_b;    alu_commit = 1'b1; end
            default:                            begin alu_res = '0;             alu_commit = 1'b0; end
        endcase

        alu_flags[FLAG_N] = alu_res[WIDTH-1];
        alu_flags[FLAG_Z] = (alu_res == '0);
        alu_flags[FLAG_C] = is_arith ? sum[WIDTH] : status_reg[FLAG_C];
        alu_flags[FLAG_V] = is_arith ? ((in_a[WIDTH-1] == op_b[WIDTH-1]) && (sum[WIDTH-1] != in_a[WIDTH-1]))
                                     : status_reg[FLAG_V];

        mul_flags[FLAG_N] = mul_product[WIDTH-1];
        mul_flags[FLAG_Z] = (mul_product == '0);
        mul_flags[FLAG_C] = status_reg[FLAG_C];
        mul_flags[FLAG_V] = status_reg[FLAG_V];
    end

    generate
        if (MUL_EN) begin : g_mul
            alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
                .clk     (clk),
                .rst     (rst),
                .start   (accept && is_mul),
                .step    (state == ST_MUL_BUSY),
                .a       (in_a),
                .b       (in_b),
                .done    (mul_done),
                .product (mul_product)
            );
        end else begin : g_no_mul
            assign mul_done    = 1'b0;
            assign mul_product = '0;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_flags  <= '0;
            status_reg <= '0;
            mul_s      <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
            state     <= ST_IDLE;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (is_mul) begin
                            state <= ST_MUL_BUSY;
                            mul_s <= in_s;
                        end else begin
                            out_valid  <= 1'b1;
                            out_result <= alu_res;
                            out_flags  <= alu_flags;
                            if (alu_commit) begin
                                status_reg <= alu_flags;
                            end
                        end
                    end
                end
                ST_MUL_BUSY: begin
                    // product is held until the output register frees up
                    if (mul_done && out_free) begin
                        out_valid  <= 1'b1;
                        out_result <= mul_product;
                        out_flags  <= mul_flags;
                        if (mul_s) begin
                            status_reg <= mul_flags;
                        end
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_alu_pipe.sv
// ----------------------------------------------------------------
// tb_alu_pipe: directed scoreboard bench for alu_pipe (WIDTH=32, MUL_EN=1)
// Revision: 1.0
// ----------------------------------------------------------------
`default_nettype none

module tb_alu_pipe;

    import alu_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   in_cmd;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_s;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_result;
    logic [3:0]   out_flags;
    logic [3:0]   status_reg;

    typedef struct packed {
        logic [W-1:0] res;
        logic [3:0]   flags;
        logic         chk_flags;
    } exp_t;

    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    alu_pipe #(.WIDTH(W), .MUL_EN(1'b1)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_cmd     (in_cmd),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_s       (in_s),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_flags  (out_flags),
        .status_reg (status_reg)
    );

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Every transfer (valid & ready, no flush) retires the oldest scoreboard entry
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && out_valid && out_ready && !flush) begin
            if (sb.size() == 0) begin
                chk("spurious_out", W'(out_valid), W'(0));
            end else begin
                e = sb.pop_front();
                chk("result", out_result, e.res);
                if (e.chk_flags) chk("flags", W'(out_flags), W'(e.flags));
            end
        end
    end

    task automatic issue(input logic [3:0] cmd, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic s, input logic push, input logic [W-1:0] er,
                         input logic [3:0] ef, input logic cf);
        int k;
        in_valid = 1'b1; in_cmd = cmd; in_a = a; in_b = b; in_s = s;
        k = 0;
        @(negedge clk);
        while (!in_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("accept", W'(in_ready), W'(1));
        if (push) sb.push_back(exp_t'{res: er, flags: ef, chk_flags: cf});
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic chk_status(input logic [3:0] e);
        @(negedge clk);
        chk("status", W'(status_reg), W'(e));
        @(posedge clk); #1;
    endtask

    task automatic wait_valid(output int cycles);
        cycles = 0;
        @(negedge clk);
        while (!out_valid && cycles < 60) begin
            cycles++;
            @(negedge clk);
        end
        @(posedge clk); #1;
    endtask

    task automatic cyc(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial begin : stim
        int busy_cyc;
        int rdy_low;
        int nv;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_cmd = '0;
        in_a = '0; in_b = '0; in_s = 1'b0; out_ready = 1'b1;
        cyc(2);
        rst = 1'b0;

        @(negedge clk);
        chk("rst_out_valid", W'(out_valid), W'(0));
        chk("rst_out_result", out_result, W'(0));
        chk("rst_out_flags", W'(out_flags), W'(0));
        chk("rst_status", W'(status_reg), W'(0));
        chk("rst_in_ready", W'(in_ready), W'(1));
        @(posedge clk); #1;

        issue(CMD_ADD, 32'h7FFF_FFFF, 32'h1, 1'b1, 1'b1, 32'h8000_0000, 4'b1001, 1'b1);
        chk_status(4'b1001);

        // ADC issued on the cycle right after SUBS must see the new carry
        issue(CMD_SUB, 32'd5, 32'd5, 1'b1, 1'b1, 32'h0, 4'b0110, 1'b1);
        issue(CMD_ADC, 32'd1, 32'd1, 1'b0, 1'b1, 32'd3, 4'b0000, 1'b1);
        chk_status(4'b0110);

        issue(CMD_MUL, 32'h0001_0000, 32'h0001_0000, 1'b1, 1'b1, 32'h0, 4'b0110, 1'b1);
        busy_cyc = 0; rdy_low = 0;
        @(negedge clk);
        while (!out_valid && busy_cyc < 60) begin
            if (!in_ready) rdy_low++;
            busy_cyc++;
            @(negedge clk);
        end
        chk("mul_latency", W'(busy_cyc), W'(32));
        chk("mul_ready_low", W'(rdy_low), W'(32));
        @(posedge clk); #1;
        chk_status(4'b0110);

        issue(CMD_MUL, 32'h1234, 32'h5678, 1'b0, 1'b1, 32'h0626_0060, 4'b0010, 1'b1);
        wait_valid(busy_cyc);
        issue(CMD_MUL, 32'hFFFF_FFFF, 32'd3, 1'b1, 1'b1, 32'hFFFF_FFFD, 4'b1010, 1'b1);
        wait_valid(busy_cyc);
        chk_status(4'b1010);

        // Stalled output: held stable, no further accept
        out_ready = 1'b0;
        issue(CMD_AND, 32'hF0, 32'h0F, 1'b1, 1'b1, 32'h0, 4'b0110, 1'b1);
        in_valid = 1'b1; in_cmd = CMD_MOV; in_b = 32'h55; in_s = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("stall_valid", W'(out_valid), W'(1));
            chk("stall_result", out_result, W'(0));
            chk("stall_ready", W'(in_ready), W'(0));
        end
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b1;
        chk_status(4'b0110);

        issue(CMD_CMP, 32'd3, 32'd5, 1'b0, 1'b1, 32'hFFFF_FFFE, 4'b1000, 1'b1);
        chk_status(4'b1000);
        issue(CMD_SBC, 32'd10, 32'd3, 1'b1, 1'b1, 32'd6, 4'b0010, 1'b1);
        issue(CMD_SBC, 32'd10, 32'd3, 1'b0, 1'b1, 32'd7, 4'b0010, 1'b1);
        chk_status(4'b0010);
        issue(CMD_TST, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h8000_0000, 4'b1010, 1'b1);
        chk_status(4'b1010);
        issue(CMD_ADDR, 32'hFFFF_FFFF, 32'd2, 1'b1, 1'b1, 32'd1, 4'b0000, 1'b0);
        chk_status(4'b1010);
        issue(CMD_EOR, 32'hFF, 32'h0F, 1'b1, 1'b1, 32'hF0, 4'b0010, 1'b1);
        chk_status(4'b0010);
        issue(CMD_MVN, 32'h0, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFFF, 4'b1010, 1'b1);
        issue(CMD_ORR, 32'h0, 32'h0, 1'b0, 1'b1, 32'h0, 4'b0110, 1'b1);
        chk_status(4'b0010);

        // Flush in the middle of a MUL
        issue(CMD_MUL, 32'd3, 32'd5, 1'b1, 1'b0, 32'h0, 4'b0000, 1'b0);
        cyc(9);
        flush = 1'b1;
        @(negedge clk);
        chk("flush_ready_low", W'(in_ready), W'(0));
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        chk("post_flush_idle", W'(in_ready), W'(1));
        nv = 0;
        repeat (40) begin
            if (out_valid) nv++;
            @(negedge clk);
        end
        chk("flush_no_out", W'(nv), W'(0));
        @(posedge clk); #1;
        chk_status(4'b0010);
        issue(CMD_ADD, 32'd2, 32'd3, 1'b0, 1'b1, 32'd5, 4'b0000, 1'b1);

        issue(4'b1011, 32'd5, 32'd7, 1'b1, 1'b1, 32'h0, 4'b0000, 1'b0);
        chk_status(4'b0010);

        // Flush together with in_valid: nothing accepted
        flush = 1'b1; in_valid = 1'b1; in_cmd = CMD_MOV; in_b = 32'hAA; in_s = 1'b1;
        @(negedge clk);
        chk("flush_in_ready", W'(in_ready), W'(0));
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("flush_no_accept", W'(out_valid), W'(0));
        @(posedge clk); #1;
        chk_status(4'b0010);

        // Flush together with out_ready: held result dropped
        out_ready = 1'b0;
        issue(CMD_MOV, 32'h0, 32'hAA, 1'b0, 1'b0, 32'h0, 4'b0000, 1'b0);
        flush = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        chk("flush_drop", W'(out_valid), W'(0));
        @(posedge clk); #1;

        // Asynchronous reset in the middle of a MUL
        issue(CMD_MUL, 32'd7, 32'd9, 1'b1, 1'b0, 32'h0, 4'b0000, 1'b0);
        cyc(5);
        #2 rst = 1'b1;
        #1;
        chk("arst_out_valid", W'(out_valid), W'(0));
        chk("arst_out_result", out_result, W'(0));
        chk("arst_status", W'(status_reg), W'(0));
        chk("arst_in_ready", W'(in_ready), W'(1));
        @(posedge clk); #1;
        rst = 1'b0;
        nv = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) nv++;
        end
        chk("arst_no_out", W'(nv), W'(0));

        chk("sb_empty", W'(sb.size()), W'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
